// File: rtl/icache_l1.sv
// rtl/icache_l1.sv - direct-mapped read-only L1 instruction cache refilled page-wise from L2
// Defining ICACHE_STATS_EN adds hit_count/miss_count outputs.
module icache_l1 #(
  parameter int PAGE_BYTES = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BYTES      = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  ready,
  output logic                  busy,
  output logic [15:0]           out,
  input  logic                  l2_busy,
  input  logic                  l2_ready,
  input  logic [15:0]           l2_data,
  output logic                  l2_start,
  input  logic                  l2_launch,
  output logic [ADDR_WIDTH-1:0] l2_page
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);
  localparam int OFF   = $clog2(PAGE_BYTES);
  localparam int LINES = BYTES / PAGE_BYTES;
  localparam int IDX   = $clog2(LINES);
  localparam int WORDS = PAGE_BYTES / 2;
  localparam int WB    = OFF - 1;
  localparam int TAGW  = ADDR_WIDTH - OFF - IDX;
  localparam logic [WB-1:0] LAST_BEAT = WB'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t                state_q, state_d;
  logic [LINES-1:0]      valid_q;
  logic [TAGW-1:0]       tag_q  [LINES];
  logic [15:0]           data_q [LINES][WORDS];
  logic [IDX-1:0]        fill_idx_q;
  logic [WB-1:0]         beat_q;
  logic [ADDR_WIDTH-1:0] page_q;

  logic [WB-1:0]   word;
  logic [IDX-1:0]  index;
  logic [TAGW-1:0] tag;
  logic            hit, miss_latch, launch, beat_wr, last_beat;
  logic            unused_addr_bit;

  assign word            = addr[OFF-1:1];
  assign index           = addr[OFF+IDX-1:OFF];
  assign tag             = addr[ADDR_WIDTH-1:OFF+IDX];
  assign unused_addr_bit = addr[0];
  assign hit             = valid_q[index] && (tag_q[index] == tag);
  assign miss_latch      = (state_q == IDLE) && !hit && !rst;
  assign launch          = l2_start && l2_launch;
  assign beat_wr         = (state_q == FILL) && l2_ready && !rst;
  assign last_beat       = beat_wr && (beat_q == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!hit) state_d = REQ;
      REQ:     if (launch) state_d = FILL;
      FILL:    if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while rst is high, whatever state the register holds.
  always_comb begin
    ready    = hit && !rst;
    busy     = (state_q != IDLE) && !rst;
    l2_start = (state_q == REQ) && !l2_busy && !rst;
    out      = data_q[index][word];
    l2_page  = page_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      beat_q     <= '0;
      page_q     <= '0;
      fill_idx_q <= '0;
    end else begin
      if (miss_latch) begin
        page_q         <= {addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
        fill_idx_q     <= index;
        valid_q[index] <= 1'b0;
      end
      if (launch)    beat_q <= '0;
      if (beat_wr)   beat_q <= beat_q + WB'(1);
      if (last_beat) valid_q[fill_idx_q] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (beat_wr)   data_q[fill_idx_q][beat_q] <= l2_data;
    if (last_beat) tag_q[fill_idx_q] <= page_q[ADDR_WIDTH-1:OFF+IDX];
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (ready)      hit_count_q  <= hit_count_q + 32'd1;
      if (miss_latch) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_icache_l1.sv
// tb/tb_icache_l1.sv - randomized self-checking bench for icache_l1 against a line-level cache model
// Build with ICACHE_STATS_EN to also check the hit/miss counters.
module tb_icache_l1;
  localparam int PB    = 32;
  localparam int LINES = 16;
  localparam int WORDS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'h0;
  logic        ready, busy, l2_start;
  logic [15:0] out;
  logic        l2_busy = 1'b0, l2_ready = 1'b0, l2_launch = 1'b0;
  logic [15:0] l2_data = 16'h0;
  logic [31:0] l2_page;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
  int unsigned exp_hits = 0, exp_misses = 0;
`endif

  always #5 clk = ~clk;

  icache_l1 #(.PAGE_BYTES(32), .ADDR_WIDTH(32), .BYTES(512)) dut (
    .clk(clk), .rst(rst), .addr(addr), .ready(ready), .busy(busy), .out(out),
    .l2_busy(l2_busy), .l2_ready(l2_ready), .l2_data(l2_data), .l2_start(l2_start),
    .l2_launch(l2_launch), .l2_page(l2_page)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int total = 0, passed = 0;

  // L2 backing store (halfword granularity) and the cache's line-level view of it.
  logic [15:0] l2m [int];
  bit          m_valid [LINES];
  int          m_tag   [LINES];

  function automatic logic [15:0] l2_get(input logic [31:0] a);
    int k = int'(a >> 1);
    if (!l2m.exists(k)) l2m[k] = 16'($urandom);
    return l2m[k];
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a / PB) % LINES);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[line_of(a)] && (m_tag[line_of(a)] == int'(a / (PB * LINES)));
  endfunction

  function automatic logic [31:0] page_of(input logic [31:0] a);
    return a - (a % PB);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
`ifdef ICACHE_STATS_EN
    exp_hits = 0;
    exp_misses = 0;
`endif
  endtask

`ifdef ICACHE_STATS_EN
  always @(posedge clk) if (!rst && m_hit(addr)) exp_hits++;
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Precondition: DUT in REQ for `page`, l2_busy low. Streams all beats, optionally probing random addresses.
  task automatic do_fill(input logic [31:0] page, input bit probe);
    int k = 0;
    l2_launch = 1'b1;
    #1;
    total++; if (l2_start !== 1'b1) $display("FAIL fill_start: got %b required 1", l2_start); else passed++;
    step();
    l2_launch = 1'b0;
    while (k < WORDS) begin
      logic [31:0] pa;
      bit gap;
      gap = probe && ($urandom_range(0, 3) == 0);
      if (probe) begin
        pa = 32'($urandom_range(0, 2047));
        addr = pa;
      end else pa = addr;
      l2_ready = !gap;
      l2_data  = gap ? 16'hDEAD : l2_get(page + 32'(2 * k));
      #1;
      total++; if (busy !== 1'b1) $display("FAIL fill_busy beat %0d: got %b required 1", k, busy); else passed++;
      if (probe) begin
        total++;
        if (ready !== m_hit(pa)) $display("FAIL probe_ready 0x%h: got %b required %b", pa, ready, m_hit(pa));
        else passed++;
        if (m_hit(pa)) begin
          total++;
          if (out !== l2_get(pa)) $display("FAIL probe_out 0x%h: got 0x%h required 0x%h", pa, out, l2_get(pa));
          else passed++;
        end
      end
      step();
      if (!gap) k++;
    end
    l2_ready = 1'b0;
    m_valid[line_of(page)] = 1'b1;
    m_tag[line_of(page)]   = int'(page / (PB * LINES));
  endtask

  // Precondition: DUT in IDLE. Looks up `a`; on a miss, serves the refill with `stall` busy cycles first.
  task automatic access(input logic [31:0] a, input int stall);
    addr = a;
    #1;
    if (m_hit(a)) begin
      total++; if (ready !== 1'b1) $display("FAIL acc_hit 0x%h: got %b required 1", a, ready); else passed++;
      total++; if (out !== l2_get(a)) $display("FAIL acc_out 0x%h: got 0x%h required 0x%h", a, out, l2_get(a)); else passed++;
      step();
    end else begin
      total++; if (ready !== 1'b0) $display("FAIL acc_miss 0x%h: got %b required 0", a, ready); else passed++;
      step();
`ifdef ICACHE_STATS_EN
      exp_misses++;
`endif
      m_valid[line_of(a)] = 1'b0;
      total++; if (busy !== 1'b1) $display("FAIL req_busy: got %b required 1", busy); else passed++;
      total++; if (l2_page !== page_of(a)) $display("FAIL req_page: got 0x%h required 0x%h", l2_page, page_of(a)); else passed++;
      l2_busy = (stall > 0);
      for (int s = 0; s < stall; s++) begin
        l2_launch = 1'b1;
        l2_ready  = 1'b1;
        l2_data   = 16'h5A5A;
        #1;
        total++; if (l2_start !== 1'b0) $display("FAIL stall_start cyc %0d: got %b required 0", s, l2_start); else passed++;
        step();
      end
      l2_busy = 1'b0; l2_launch = 1'b0; l2_ready = 1'b0;
      do_fill(page_of(a), 1'b1);
      addr = a;
      #1;
      total++; if (ready !== 1'b1) $display("FAIL post_fill_ready 0x%h: got %b required 1", a, ready); else passed++;
      total++; if (out !== l2_get(a)) $display("FAIL post_fill_out 0x%h: got 0x%h required 0x%h", a, out, l2_get(a)); else passed++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    addr = 32'h100;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (ready !== 1'b0) $display("FAIL rst_ready cyc %0d: got %b required 0", c, ready); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL rst_busy cyc %0d: got %b required 0", c, busy); else passed++;
      total++; if (l2_start !== 1'b0) $display("FAIL rst_start cyc %0d: got %b required 0", c, l2_start); else passed++;
      step();
    end
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL rel_busy: got %b required 0", busy); else passed++;
    total++; if (l2_start !== 1'b0) $display("FAIL rel_start: got %b required 0", l2_start); else passed++;
    step();
`ifdef ICACHE_STATS_EN
    exp_misses++;
`endif
    total++; if (busy !== 1'b1) $display("FAIL req_busy0: got %b required 1", busy); else passed++;
    total++; if (l2_start !== 1'b1) $display("FAIL req_start0: got %b required 1", l2_start); else passed++;
    total++; if (l2_page !== 32'h100) $display("FAIL req_page0: got 0x%h required 0x100", l2_page); else passed++;
  endtask

  task automatic test_cold_fill();
    for (int k = 0; k < WORDS; k++) l2m[(32'h100 >> 1) + k] = 16'hA000 + 16'(k);
    do_fill(32'h100, 1'b0);
    #1;
    total++; if (ready !== 1'b1) $display("FAIL cold_ready: got %b required 1", ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL cold_busy: got %b required 0", busy); else passed++;
    total++; if (out !== 16'hA000) $display("FAIL cold_out_100: got 0x%h required 0xa000", out); else passed++;
    addr = 32'h11E;
    #1;
    total++; if (out !== 16'hA00F) $display("FAIL cold_out_11e: got 0x%h required 0xa00f", out); else passed++;
    addr = 32'h10B;
    #1;
    total++; if (out !== 16'hA005) $display("FAIL cold_out_10a: got 0x%h required 0xa005", out); else passed++;
    step();
  endtask

  task automatic test_l2_busy();
    access(32'h240, 5);
  endtask

  task automatic test_conflict();
    access(32'h300, 0);
    access(32'h100, 0);
  endtask

  task automatic test_hit_during_fill();
    access(32'h040, 0);
    addr = 32'h300;
    #1;
    total++; if (ready !== 1'b0) $display("FAIL hdf_miss: got %b required 0", ready); else passed++;
    step();
`ifdef ICACHE_STATS_EN
    exp_misses++;
`endif
    m_valid[line_of(32'h300)] = 1'b0;
    l2_launch = 1'b1;
    step();
    l2_launch = 1'b0;
    for (int k = 0; k < WORDS; k++) begin
      l2_ready = 1'b1;
      l2_data  = l2_get(32'h300 + 32'(2 * k));
      addr = 32'h040;
      #1;
      total++; if (ready !== 1'b1) $display("FAIL hdf_other_ready: got %b required 1", ready); else passed++;
      total++; if (out !== l2_get(32'h040)) $display("FAIL hdf_other_out: got 0x%h required 0x%h", out, l2_get(32'h040)); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL hdf_busy: got %b required 1", busy); else passed++;
      addr = 32'h302;
      #1;
      total++; if (ready !== 1'b0) $display("FAIL hdf_self_ready beat %0d: got %b required 0", k, ready); else passed++;
      step();
    end
    l2_ready = 1'b0;
    m_valid[line_of(32'h300)] = 1'b1;
    m_tag[line_of(32'h300)]   = int'(32'h300 / (PB * LINES));
    #1;
    total++; if (ready !== 1'b1) $display("FAIL hdf_done_ready: got %b required 1", ready); else passed++;
    total++; if (out !== l2_get(32'h302)) $display("FAIL hdf_done_out: got 0x%h required 0x%h", out, l2_get(32'h302)); else passed++;
    step();
  endtask

  task automatic test_reset_mid_fill();
    addr = 32'h100;
    #1;
    step();
`ifdef ICACHE_STATS_EN
    exp_misses++;
`endif
    l2_launch = 1'b1;
    step();
    l2_launch = 1'b0;
    for (int k = 0; k < 8; k++) begin
      l2_ready = 1'b1;
      l2_data  = l2_get(32'h100 + 32'(2 * k));
      step();
    end
    rst = 1'b1;
    l2_data = 16'hBEEF;
    model_reset();
    step();
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL rmf_busy: got %b required 0", busy); else passed++;
    total++; if (l2_start !== 1'b0) $display("FAIL rmf_start: got %b required 0", l2_start); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL rmf_ready_100: got %b required 0", ready); else passed++;
`ifdef ICACHE_STATS_EN
    total++; if (hit_count !== 32'd0) $display("FAIL rmf_hit_count: got %0d required 0", hit_count); else passed++;
    total++; if (miss_count !== 32'd0) $display("FAIL rmf_miss_count: got %0d required 0", miss_count); else passed++;
`endif
    addr = 32'h040;
    #1;
    total++; if (ready !== 1'b0) $display("FAIL rmf_ready_040: got %b required 0", ready); else passed++;
    step();
`ifdef ICACHE_STATS_EN
    exp_misses++;
`endif
    l2_ready = 1'b0;
    total++; if (l2_page !== 32'h040) $display("FAIL rmf_page: got 0x%h required 0x40", l2_page); else passed++;
    do_fill(32'h040, 1'b1);
    addr = 32'h040;
    #1;
    total++; if (out !== l2_get(32'h040)) $display("FAIL rmf_refill_out: got 0x%h required 0x%h", out, l2_get(32'h040)); else passed++;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      access(32'($urandom_range(0, 2047)), int'($urandom_range(0, 2)));
`ifdef ICACHE_STATS_EN
    #1;
    total++; if (hit_count !== 32'(exp_hits)) $display("FAIL hit_count: got %0d required %0d", hit_count, exp_hits); else passed++;
    total++; if (miss_count !== 32'(exp_misses)) $display("FAIL miss_count: got %0d required %0d", miss_count, exp_misses); else passed++;
`endif
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_cold_fill();
    test_l2_busy();
    test_conflict();
    test_hit_during_fill();
    test_reset_mid_fill();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
